// File: rtl/piezo_pkg.sv
// Shared types and constants for the piezo arbiter slice.
// State encoding, note half-periods at 50 MHz and tune durations.
package piezo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_NOTE,
        PLAY,
        GAP
    } arb_state_t;

    localparam logic [15:0] G6 = 16'd15944;
    localparam logic [15:0] C7 = 16'd11945;
    localparam logic [15:0] E7 = 16'd9480;
    localparam logic [15:0] G7 = 16'd7972;

    localparam logic [23:0] DUR_22 = 24'h400000;
    localparam logic [23:0] DUR_23 = 24'h800000;

endpackage

// File: rtl/piezo_tone_gen.sv
// Square-wave tone generator: toggles piezo every half_per enabled cycles.
// Ports: clk, rst (sync, high), en (count), clr (restart), half_per, piezo.
module piezo_tone_gen
    import piezo_pkg::*;
#(
    parameter int PER_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [PER_W-1:0] half_per,
    output logic             piezo
);

    logic [PER_W-1:0] tc;
    logic             wrap;

    assign wrap = (tc == half_per - PER_W'(1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            tc    <= '0;
            piezo <= 1'b0;
        end else if (en && (half_per != '0)) begin
            if (wrap) begin
                tc    <= '0;
                piezo <= ~piezo;
            end else begin
                tc <= tc + PER_W'(1);
            end
        end
    end

endmodule

// File: rtl/piezo_arb.sv
// Piezo owner: fixed-priority tune arbitration, note timing and tone drive.
// Ports: clk, rst, req_vld/rdy/half_per/dur/last per requester, grant,
//        busy, note_done, piezo, piezo_n.
module piezo_arb
    import piezo_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int PER_W    = 16,
    parameter int DUR_W    = 24,
    parameter int FAST_SIM = 1,
    parameter int GAP_CYC  = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_vld,
    output logic [NUM_REQ-1:0]       req_rdy,
    input  logic [NUM_REQ*PER_W-1:0] req_half_per,
    input  logic [NUM_REQ*DUR_W-1:0] req_dur,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy,
    output logic                     note_done,
    output logic                     piezo,
    output logic                     piezo_n
);

    localparam logic [DUR_W:0] STEP =
        (FAST_SIM != 0) ? (DUR_W+1)'(16) : (DUR_W+1)'(1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    arb_state_t state_q, state_d;

    logic [NUM_REQ-1:0] grant_q, grant_d, pick;
    logic [PER_W-1:0]   half_q, sel_half;
    logic [DUR_W-1:0]   dur_q, dur_cnt, sel_dur;
    logic [DUR_W:0]     dur_sum;
    logic [GAP_W-1:0]   gap_cnt;
    logic               last_q, sel_last;
    logic               hs, play_end, gap_done;
    logic               tone, sounding;

    // Lowest set index wins: isolate the least significant request bit.
    assign pick = req_vld & (~req_vld + NUM_REQ'(1));

    always_comb begin
        sel_half = '0;
        sel_dur  = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                sel_half = req_half_per[i*PER_W +: PER_W];
                sel_dur  = req_dur[i*DUR_W +: DUR_W];
                sel_last = req_last[i];
            end
        end
    end

    assign hs = (state_q == WAIT_NOTE) && |(req_vld & grant_q);

    // One extra bit so the end test cannot be fooled by a wrap.
    assign dur_sum  = {1'b0, dur_cnt} + STEP;
    assign play_end = (dur_sum >= {1'b0, dur_q});
    assign gap_done = (gap_cnt == GAP_W'(GAP_CYC - 1));

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        req_rdy   = '0;
        note_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req_vld) begin
                    grant_d = pick;
                    state_d = WAIT_NOTE;
                end
            end
            WAIT_NOTE: begin
                req_rdy = grant_q;
                if (hs) state_d = PLAY;
            end
            PLAY: begin
                if (play_end) begin
                    note_done = 1'b1;
                    if (last_q) begin
                        state_d = GAP;
                        grant_d = '0;
                    end else begin
                        state_d = WAIT_NOTE;
                    end
                end
            end
            GAP: begin
                if (gap_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            half_q  <= '0;
            dur_q   <= '0;
            last_q  <= 1'b0;
            dur_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            if (hs) begin
                half_q  <= sel_half;
                dur_q   <= sel_dur;
                last_q  <= sel_last;
                dur_cnt <= '0;
            end else if (state_q == PLAY) begin
                dur_cnt <= dur_sum[DUR_W-1:0];
            end
            if (state_q == GAP) begin
                gap_cnt <= gap_done ? '0 : gap_cnt + GAP_W'(1);
            end else begin
                gap_cnt <= '0;
            end
        end
    end

    piezo_tone_gen #(
        .PER_W(PER_W)
    ) u_tone (
        .clk     (clk),
        .rst     (rst),
        .en      (state_q == PLAY),
        .clr     (hs),
        .half_per(half_q),
        .piezo   (tone)
    );

    // Drive pair only while a pitched note plays; otherwise both low.
    assign sounding = (state_q == PLAY) && (half_q != '0);
    assign piezo    = sounding & tone;
    assign piezo_n  = sounding & ~tone;
    assign busy     = (state_q != IDLE);
    assign grant    = grant_q;

endmodule

// File: tb/tb_piezo_arb.sv
// Directed bench for piezo_arb: arbitration, note timing, tone, gap, reset.
// Default parameters: FAST_SIM=1 (step 16), GAP_CYC=1024.
module tb_piezo_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_vld;
    logic [2:0]  req_rdy;
    logic [47:0] req_half_per;
    logic [71:0] req_dur;
    logic [2:0]  req_last;
    logic [2:0]  grant;
    logic        busy;
    logic        note_done;
    logic        piezo;
    logic        piezo_n;

    int n_chk   = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int illegal = 0;

    always #5 clk = ~clk;

    piezo_arb dut (
        .clk         (clk),
        .rst         (rst),
        .req_vld     (req_vld),
        .req_rdy     (req_rdy),
        .req_half_per(req_half_per),
        .req_dur     (req_dur),
        .req_last    (req_last),
        .grant       (grant),
        .busy        (busy),
        .note_done   (note_done),
        .piezo       (piezo),
        .piezo_n     (piezo_n)
    );

    always @(negedge clk) begin
        if (note_done) done_cnt++;
        if (piezo && piezo_n) illegal++;
        if (!busy && (piezo || piezo_n)) illegal++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_note(input int i, input int hp, input int dur,
                            input bit last);
        req_half_per[i*16 +: 16] = hp[15:0];
        req_dur[i*24 +: 24]      = dur[23:0];
        req_last[i]              = last;
        req_vld[i]               = 1'b1;
    endtask

    task automatic play(input int i, input int hp, input int dur,
                        input bit last, output int len, output int hi,
                        output int nhi, output int first, output int bad);
        int w;
        logic [2:0] me;
        me    = 3'b001 << i;
        len   = 0;
        hi    = 0;
        nhi   = 0;
        first = 0;
        bad   = 0;
        set_note(i, hp, dur, last);
        #1;
        w = 0;
        while (!req_rdy[i] && w < 20) begin
            if (note_done) bad++;
            if ((req_rdy & ~me) != 3'b000) bad++;
            tick();
            w++;
        end
        check("hs_rdy", {31'd0, req_rdy[i]}, 32'd1);
        check("hs_grant", {29'd0, grant}, {29'd0, me});
        tick();
        req_vld[i] = 1'b0;
        #1;
        while (len < 4000) begin
            len++;
            if (piezo) begin
                hi++;
                if (first == 0) first = len;
            end
            if (piezo_n) nhi++;
            if (req_rdy != 3'b000) bad++;
            if (grant != me) bad++;
            if (note_done) break;
            tick();
        end
        tick();
    endtask

    task automatic wait_idle(output int n, output int rdy_seen);
        n        = 0;
        rdy_seen = 0;
        while (busy && n < 3000) begin
            n++;
            if (req_rdy != 3'b000) rdy_seen++;
            tick();
        end
    endtask

    int len, hi, nhi, first, bad, n, rs, d0, w;

    initial begin
        rst          = 1'b1;
        req_vld      = '0;
        req_half_per = '0;
        req_dur      = '0;
        req_last     = '0;
        repeat (3) tick();
        check("rst_grant", {29'd0, grant}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_piezo", {31'd0, piezo}, 0);
        check("rst_piezo_n", {31'd0, piezo_n}, 0);
        check("rst_done", {31'd0, note_done}, 0);
        check("rst_rdy", {29'd0, req_rdy}, 0);
        rst = 1'b0;
        tick();
        check("idle_busy", {31'd0, busy}, 0);

        // single pitched note, tone visible inside PLAY
        d0 = done_cnt;
        play(0, 4, 128, 1'b1, len, hi, nhi, first, bad);
        check("t1_len", len, 8);
        check("t1_hi", hi, 4);
        check("t1_nhi", nhi, 4);
        check("t1_first_rise", first, 5);
        check("t1_bad", bad, 0);
        check("t1_done_cnt", done_cnt - d0, 1);
        check("t1_gap_grant", {29'd0, grant}, 0);
        check("t1_gap_busy", {31'd0, busy}, 1);
        wait_idle(n, rs);
        check("t1_gap_len", n, 1024);
        check("t1_idle_busy", {31'd0, busy}, 0);

        // dur 64: four PLAY cycles, rise would land after PLAY
        play(0, 4, 64, 1'b1, len, hi, nhi, first, bad);
        check("t1b_len", len, 4);
        check("t1b_hi", hi, 0);
        check("t1b_bad", bad, 0);
        wait_idle(n, rs);

        // simultaneous 0 and 2: 0 first, 2 after the gap
        set_note(2, 5, 48, 1'b1);
        play(0, 3, 32, 1'b1, len, hi, nhi, first, bad);
        check("t2_len0", len, 2);
        check("t2_bad0", bad, 0);
        wait_idle(n, rs);
        check("t2_gap_len", n, 1024);
        check("t2_gap_rdy", rs, 0);
        tick();
        check("t2_grant2", {29'd0, grant}, 3'b100);
        play(2, 5, 48, 1'b1, len, hi, nhi, first, bad);
        check("t2_len2", len, 3);
        check("t2_bad2", bad, 0);
        wait_idle(n, rs);

        // no preemption of a three-note tune
        d0 = done_cnt;
        play(1, 3, 32, 1'b0, len, hi, nhi, first, bad);
        check("t3_len_a", len, 2);
        set_note(0, 2, 16, 1'b1);
        play(1, 2, 48, 1'b0, len, hi, nhi, first, bad);
        check("t3_len_b", len, 3);
        check("t3_bad_b", bad, 0);
        play(1, 1, 16, 1'b1, len, hi, nhi, first, bad);
        check("t3_len_c", len, 1);
        check("t3_bad_c", bad, 0);
        check("t3_done_cnt", done_cnt - d0, 3);
        check("t3_gap_grant", {29'd0, grant}, 0);
        wait_idle(n, rs);
        check("t3_gap_len", n, 1024);
        check("t3_gap_rdy", rs, 0);
        tick();
        check("t3_grant0", {29'd0, grant}, 3'b001);
        play(0, 2, 16, 1'b1, len, hi, nhi, first, bad);
        check("t3_len0", len, 1);
        wait_idle(n, rs);

        // rest note is silent on both pins
        play(0, 0, 160, 1'b1, len, hi, nhi, first, bad);
        check("t4_len", len, 10);
        check("t4_hi", hi, 0);
        check("t4_nhi", nhi, 0);
        wait_idle(n, rs);

        // zero duration: one PLAY cycle, no toggle
        play(0, 2, 0, 1'b1, len, hi, nhi, first, bad);
        check("t6_len", len, 1);
        check("t6_hi", hi, 0);
        check("t6_nhi", nhi, 1);
        wait_idle(n, rs);

        // reset in the middle of a note
        set_note(0, 1, 1600, 1'b1);
        #1;
        w = 0;
        while (!req_rdy[0] && w < 20) begin
            tick();
            w++;
        end
        check("t5_rdy", {31'd0, req_rdy[0]}, 1);
        tick();
        req_vld = '0;
        tick();
        check("t5_tone", {31'd0, piezo}, 1);
        check("t5_busy_pre", {31'd0, busy}, 1);
        d0  = done_cnt;
        rst = 1'b1;
        tick();
        check("t5_busy", {31'd0, busy}, 0);
        check("t5_grant", {29'd0, grant}, 0);
        check("t5_piezo", {31'd0, piezo}, 0);
        check("t5_piezo_n", {31'd0, piezo_n}, 0);
        check("t5_done", {31'd0, note_done}, 0);
        check("t5_rdy0", {29'd0, req_rdy}, 0);
        rst = 1'b0;
        tick();
        check("t5_no_pulse", done_cnt - d0, 0);

        check("pin_pair_legal", illegal, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
